// File: rtl/ifetch.sv
// Instruction fetch: one outstanding imem request; word is held for decode until taken or flushed.
// Latency: instr_valid >= 2 cycles after request accept; stalls on imem_req_ready and instr_ready.
module ifetch #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        pc_advance,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD} state_t;

    state_t state;
    logic   aligned;

    assign aligned        = (pc[1:0] == 2'b00);
    assign imem_req_valid = (state == REQ) && aligned;
    assign imem_req_addr  = imem_req_valid ? pc : 32'h0;
    assign instr_valid    = (state == HOLD);
    assign pc_advance     = instr_valid && instr_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            instr_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    // An accept under flush is still in flight; its response must be drained.
                    if (imem_req_valid && imem_req_ready) begin
                        instr_pc <= pc;
                        state    <= flush ? DROP : WAIT;
                    end else if (!flush && !aligned) begin
                        instr       <= NOP_INSTR;
                        instr_pc    <= pc;
                        instr_fault <= 1'b1;
                        state       <= HOLD;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (flush) begin
                            state <= REQ;
                        end else begin
                            instr       <= imem_rsp_data;
                            instr_fault <= 1'b0;
                            state       <= HOLD;
                        end
                    end else if (flush) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) begin
                        state <= REQ;
                    end
                end
                HOLD: begin
                    if (flush || instr_ready) begin
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios plus a randomized run against a transaction-level model.
module tb_ifetch;
    logic        clk = 1'b0;
    logic        reset, flush, imem_req_ready, imem_rsp_valid, instr_ready;
    logic [31:0] pc, imem_rsp_data;
    logic        pc_advance, imem_req_valid, instr_valid, instr_fault;
    logic [31:0] imem_req_addr, instr, instr_pc;
    int          total = 0;
    int          bad = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    ifetch dut (
        .clk(clk), .reset(reset), .pc(pc), .flush(flush), .pc_advance(pc_advance),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .instr_fault(instr_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0] ^ 16'h0F0F};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into the first cycle with reset low (DUT in IDLE).
    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0; instr_ready = 1'b0; pc = 32'h0;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hFFFF_FFFF; instr_ready = 1'b1; pc = 32'h0;
        cyc(); cyc(); #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req_valid); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr); end
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", instr_pc); end
        total++; if (instr_fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b exp=0", instr_fault); end
        reset = 1'b0; imem_req_ready = 1'b0; instr_ready = 1'b0; #1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL idle_req got=%b exp=0", imem_req_valid); end
        total++; if (pc_advance !== 1'b0) begin bad++; $display("FAIL idle_adv got=%b exp=0", pc_advance); end
        cyc(); #1;
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL first_req got=%b exp=1", imem_req_valid); end
        total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL first_addr got=%h exp=0", imem_req_addr); end
        cyc(); #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stray_rsp_valid got=%b exp=0", instr_valid); end
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL stray_rsp_req got=%b exp=1", imem_req_valid); end
        imem_rsp_valid = 1'b0;
    endtask

    task automatic test_basic();
        do_reset(); pc = 32'h0; imem_req_ready = 1'b1;
        cyc(); #1;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL basic_req got=%b/%h exp=1/0", imem_req_valid, imem_req_addr); end
        cyc(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093; #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL basic_wait_valid got=%b exp=0", instr_valid); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL basic_one_outstanding got=%b exp=0", imem_req_valid); end
        cyc(); imem_rsp_valid = 1'b0; instr_ready = 1'b1; #1;
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", instr_valid); end
        total++; if (instr !== 32'h0050_0093) begin bad++; $display("FAIL basic_instr got=%h exp=00500093", instr); end
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL basic_pc got=%h exp=0", instr_pc); end
        total++; if (instr_fault !== 1'b0) begin bad++; $display("FAIL basic_fault got=%b exp=0", instr_fault); end
        total++; if (pc_advance !== 1'b1) begin bad++; $display("FAIL basic_adv got=%b exp=1", pc_advance); end
        cyc(); pc = 32'h4; instr_ready = 1'b0; #1;
        total++; if (pc_advance !== 1'b0) begin bad++; $display("FAIL basic_adv_once got=%b exp=0", pc_advance); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin bad++; $display("FAIL basic_next_req got=%b/%h exp=1/4", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_req_stall();
        do_reset(); pc = 32'h8;
        cyc();
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin bad++; $display("FAIL stall_req k=%0d got=%b/%h exp=1/8", k, imem_req_valid, imem_req_addr); end
            total++; if (pc_advance !== 1'b0) begin bad++; $display("FAIL stall_adv k=%0d got=%b exp=0", k, pc_advance); end
            cyc();
        end
        imem_req_ready = 1'b1;
        cyc(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
        cyc(); imem_rsp_valid = 1'b0; #1;
        total++; if (instr_valid !== 1'b1 || instr !== 32'h1111_1111 || instr_pc !== 32'h8) begin bad++; $display("FAIL stall_hold got=%b/%h/%h exp=1/11111111/8", instr_valid, instr, instr_pc); end
    endtask

    task automatic test_hold_stall();
        do_reset(); pc = 32'h10; imem_req_ready = 1'b1;
        cyc();
        cyc(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        cyc(); imem_rsp_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (instr_valid !== 1'b1 || instr !== 32'h1234_5678 || instr_pc !== 32'h10) begin bad++; $display("FAIL hold_stable k=%0d got=%b/%h/%h exp=1/12345678/10", k, instr_valid, instr, instr_pc); end
            total++; if (imem_req_valid !== 1'b0 || pc_advance !== 1'b0) begin bad++; $display("FAIL hold_quiet k=%0d got=%b/%b exp=0/0", k, imem_req_valid, pc_advance); end
            cyc();
        end
        instr_ready = 1'b1; #1;
        total++; if (pc_advance !== 1'b1) begin bad++; $display("FAIL hold_release got=%b exp=1", pc_advance); end
    endtask

    task automatic test_flush_wait();
        do_reset(); pc = 32'h20; imem_req_ready = 1'b1;
        cyc();
        cyc(); imem_req_ready = 1'b0; flush = 1'b1; #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL fw_flush_valid got=%b exp=0", instr_valid); end
        cyc(); flush = 1'b0; pc = 32'h40; #1;
        total++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL fw_drop got=%b/%b exp=0/0", imem_req_valid, instr_valid); end
        cyc(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; #1;
        total++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL fw_rsp got=%b/%b exp=0/0", imem_req_valid, instr_valid); end
        cyc(); imem_rsp_valid = 1'b0; #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL fw_dropped_valid got=%b exp=0", instr_valid); end
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin bad++; $display("FAIL fw_new_req got=%b/%h exp=1/40", imem_req_valid, imem_req_addr); end
        cyc(); #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL fw_still_dropped got=%b exp=0", instr_valid); end
    endtask

    task automatic test_flush_req_hold();
        do_reset(); pc = 32'h30; imem_req_ready = 1'b1;
        cyc(); flush = 1'b1; #1;
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL fr_req got=%b exp=1", imem_req_valid); end
        cyc(); flush = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_0000; #1;
        total++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL fr_drop got=%b/%b exp=0/0", imem_req_valid, instr_valid); end
        cyc(); imem_rsp_valid = 1'b0; #1;
        total++; if (imem_req_valid !== 1'b1 || instr_valid !== 1'b0) begin bad++; $display("FAIL fr_reissue got=%b/%b exp=1/0", imem_req_valid, instr_valid); end
        cyc(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0067;
        cyc(); imem_rsp_valid = 1'b0; instr_ready = 1'b1; flush = 1'b1; #1;
        total++; if (instr_valid !== 1'b1 || instr !== 32'h0000_0067) begin bad++; $display("FAIL fh_valid got=%b/%h exp=1/00000067", instr_valid, instr); end
        total++; if (pc_advance !== 1'b0) begin bad++; $display("FAIL fh_adv got=%b exp=0", pc_advance); end
        cyc(); flush = 1'b0; instr_ready = 1'b0; imem_req_ready = 1'b0; #1;
        total++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1) begin bad++; $display("FAIL fh_req got=%b/%b exp=0/1", instr_valid, imem_req_valid); end
    endtask

    task automatic test_misaligned();
        do_reset(); pc = 32'h6; imem_req_ready = 1'b1;
        cyc(); #1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL mis_req got=%b exp=0", imem_req_valid); end
        cyc(); #1;
        total++; if (instr_valid !== 1'b1 || instr !== NOP) begin bad++; $display("FAIL mis_instr got=%b/%h exp=1/%h", instr_valid, instr, NOP); end
        total++; if (instr_fault !== 1'b1 || instr_pc !== 32'h6) begin bad++; $display("FAIL mis_fault got=%b/%h exp=1/6", instr_fault, instr_pc); end
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL mis_hold_req got=%b exp=0", imem_req_valid); end
    endtask

    task automatic test_reset_in_hold();
        do_reset(); pc = 32'h50; imem_req_ready = 1'b1;
        cyc();
        cyc(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_00EF;
        cyc(); imem_rsp_valid = 1'b0; instr_ready = 1'b1; reset = 1'b1; #1;
        total++; if (pc_advance !== 1'b1) begin bad++; $display("FAIL rh_adv got=%b exp=1", pc_advance); end
        cyc(); reset = 1'b0; #1;
        total++; if (instr_valid !== 1'b0 || pc_advance !== 1'b0) begin bad++; $display("FAIL rh_idle got=%b/%b exp=0/0", instr_valid, pc_advance); end
        total++; if (instr !== 32'h0 || instr_pc !== 32'h0 || instr_fault !== 1'b0) begin bad++; $display("FAIL rh_clear got=%h/%h/%b exp=0/0/0", instr, instr_pc, instr_fault); end
    endtask

    // Model tracks only "an instruction is held" and "a request is in flight".
    task automatic test_random();
        logic held, outst, doomed, acc, rsp, exp_adv, free, e_fault;
        logic [31:0] e_instr, e_pc, o_addr, cur_pc;
        int cnt, n_adv;
        do_reset(); cyc();
        held = 1'b0; outst = 1'b0; doomed = 1'b0; cnt = 0; n_adv = 0;
        cur_pc = 32'h100; o_addr = 32'h0; e_instr = 32'h0; e_pc = 32'h0; e_fault = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            pc = cur_pc;
            flush = ($urandom_range(0, 11) == 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            rsp = outst && (cnt == 0);
            imem_rsp_valid = rsp;
            imem_rsp_data = rsp ? data_of(o_addr) : $urandom;
            free = !held && !outst;
            exp_adv = held && instr_ready && !flush;
            #1;
            total++; if (instr_valid !== held) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, instr_valid, held); end
            total++; if (imem_req_valid !== (free && cur_pc[1:0] == 2'b00)) begin bad++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, imem_req_valid, free && cur_pc[1:0] == 2'b00); end
            total++; if (pc_advance !== exp_adv) begin bad++; $display("FAIL rnd_adv cyc=%0d got=%b exp=%b", i, pc_advance, exp_adv); end
            if (held) begin
                total++; if (instr !== e_instr) begin bad++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", i, instr, e_instr); end
                total++; if (instr_pc !== e_pc) begin bad++; $display("FAIL rnd_ipc cyc=%0d got=%h exp=%h", i, instr_pc, e_pc); end
                total++; if (instr_fault !== e_fault) begin bad++; $display("FAIL rnd_fault cyc=%0d got=%b exp=%b", i, instr_fault, e_fault); end
            end
            if (free && cur_pc[1:0] == 2'b00) begin
                total++; if (imem_req_addr !== cur_pc) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, imem_req_addr, cur_pc); end
            end
            acc = free && (cur_pc[1:0] == 2'b00) && imem_req_ready;
            if (rsp) outst = 1'b0;
            else if (outst) cnt--;
            if (acc) begin
                outst = 1'b1; o_addr = cur_pc; cnt = $urandom_range(0, 2); doomed = flush;
            end else if (flush) begin
                doomed = 1'b1;
            end
            if (flush) begin
                held = 1'b0;
            end else begin
                if (held && instr_ready) held = 1'b0;
                if (free && cur_pc[1:0] != 2'b00) begin
                    held = 1'b1; e_instr = NOP; e_pc = cur_pc; e_fault = 1'b1;
                end
                if (rsp && !doomed) begin
                    held = 1'b1; e_instr = data_of(o_addr); e_pc = o_addr; e_fault = 1'b0;
                end
            end
            if (flush) cur_pc = (32'($urandom_range(64, 1023)) << 2) + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
            else if (exp_adv) begin cur_pc = cur_pc + 32'd4; n_adv++; end
            cyc();
        end
        total++; if (n_adv < 100) begin bad++; $display("FAIL rnd_progress got=%0d exp>=100", n_adv); end
        flush = 1'b0; imem_rsp_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_req_stall();
        test_hold_stall();
        test_flush_wait();
        test_flush_req_hold();
        test_misaligned();
        test_reset_in_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter: NOP_INSTR, 32'h0000_0013, instruction word presented on a misaligned-fetch fault.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 pc  input  32  current fetch address, driven by the program-counter register.
REQ-005 flush  input  1  redirect; discards any in-flight or held instruction.
REQ-006 pc_advance  output  1  one-cycle pulse; program counter loads pc_next on this cycle.
REQ-007 imem_req_valid  output  1  instruction-memory request valid.
REQ-008 imem_req_ready  input  1  instruction memory accepts the request.
REQ-009 imem_req_addr  output  32  request address.
REQ-010 imem_rsp_valid  input  1  response data valid; exactly one response per accepted request, no back-pressure.
REQ-011 imem_rsp_data  input  32  response instruction word.
REQ-012 instr_valid  output  1  decode-side instruction valid.
REQ-013 instr_ready  input  1  decode accepts the instruction.
REQ-014 instr  output  32  held instruction word.
REQ-015 instr_pc  output  32  address of the held instruction.
REQ-016 instr_fault  output  1  held instruction results from a misaligned pc.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT, DROP and HOLD.
REQ-018 IDLE: all outputs 0; next state REQ unconditionally.
REQ-019 REQ, pc[1:0]==0: imem_req_valid=1 and imem_req_addr=pc (combinational); on imem_req_ready, latch pc into instr_pc and go to WAIT; otherwise stay.
REQ-020 REQ, pc[1:0]!=0: imem_req_valid=0; latch instr=NOP_INSTR, instr_pc=pc and instr_fault=1; go to HOLD.
REQ-021 WAIT: on imem_rsp_valid, latch instr=imem_rsp_data and instr_fault=0; go to HOLD; earliest instr_valid is 2 cycles after request acceptance.
REQ-022 HOLD: instr_valid=1 and instr/instr_pc/instr_fault stable; on instr_ready go to REQ.
REQ-023 pc_advance SHALL equal (state==HOLD) & instr_ready & ~flush.
REQ-024 flush in REQ: state remains REQ, and any request accepted in the same cycle is treated as in-flight, so the next state is DROP.
REQ-025 flush in WAIT without imem_rsp_valid: go to DROP; with imem_rsp_valid: discard the data and go to REQ.
REQ-026 DROP: instr_valid=0 and imem_req_valid=0; on imem_rsp_valid, discard the data and go to REQ.
REQ-027 flush in HOLD: drop the instruction, pc_advance=0, go to REQ even if instr_ready=1.
REQ-028 flush SHALL take priority over every handshake in the same cycle.
REQ-029 At most one request SHALL be outstanding at any time.
REQ-030 instr_valid, once asserted, SHALL NOT deassert before instr_ready or flush.

Reset
REQ-031 reset SHALL force state=IDLE, instr=0, instr_pc=0 and instr_fault=0 on the next posedge, overriding all other inputs including mid-transaction states.
REQ-032 A response arriving after reset SHALL be ignored while the FSM is in IDLE or REQ.
REQ-033 The first request SHALL issue in the second cycle after reset deasserts.

Verification
REQ-034 Scenario: reset released, pc=0, imem_req_ready=1, response 1 cycle later with 32'h00500093, instr_ready=1 -> instr_valid with instr=32'h00500093 and instr_pc=0, then pc_advance pulses once.
REQ-035 Scenario: imem_req_ready held 0 for 3 cycles -> imem_req_valid stays 1 with a stable address and pc_advance stays 0 throughout.
REQ-036 Scenario: instr_ready=0 for 4 cycles in HOLD -> instr, instr_pc and instr_valid stay stable and no new request issues.
REQ-037 Scenario: flush in WAIT, response 32'hDEADBEEF 2 cycles later -> data dropped, instr_valid never 1 for it, new request issues next cycle.
REQ-038 Scenario: pc=32'h0000_0006 -> no memory request; instr=32'h0000_0013, instr_fault=1, instr_pc=32'h0000_0006.
REQ-039 Scenario: reset asserted in HOLD with instr_ready=1 -> pc_advance=1 that cycle (reset is synchronous, outputs follow the HOLD state), then IDLE with instr_valid=0 and pc_advance=0.
